// File: rtl/seq_pkg.sv
// Shared types and 7-segment constants for the sequence hit counter.
// Segment vectors are active-high and ordered {g,f,e,d,c,b,a}.
package seq_pkg;

    typedef enum logic [0:0] {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } trk_state_t;

    localparam logic [6:0] SEG7_0    = 7'b0111111;
    localparam logic [6:0] SEG7_1    = 7'b0000110;
    localparam logic [6:0] SEG7_2    = 7'b1011011;
    localparam logic [6:0] SEG7_3    = 7'b1001111;
    localparam logic [6:0] SEG7_4    = 7'b1100110;
    localparam logic [6:0] SEG7_5    = 7'b1101101;
    localparam logic [6:0] SEG7_6    = 7'b1111101;
    localparam logic [6:0] SEG7_7    = 7'b0000111;
    localparam logic [6:0] SEG7_8    = 7'b1111111;
    localparam logic [6:0] SEG7_9    = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-BCD codes blank the digit rather than show garbage.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = SEG7_0;
            4'd1:    segs = SEG7_1;
            4'd2:    segs = SEG7_2;
            4'd3:    segs = SEG7_3;
            4'd4:    segs = SEG7_4;
            4'd5:    segs = SEG7_5;
            4'd6:    segs = SEG7_6;
            4'd7:    segs = SEG7_7;
            4'd8:    segs = SEG7_8;
            4'd9:    segs = SEG7_9;
            default: segs = SEG_BLANK;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single mod-10 BCD digit with increment, clear and a combinational carry.
// carry_out is high in the cycle an increment rolls the digit 9 -> 0.
module bcd_digit
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry_out
);

    logic [3:0] value_r;

    // Digit register; any value >= 9 rolls to 0 so the digit never leaves 0..9.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= 4'd0;
        end else if (clr) begin
            value_r <= 4'd0;
        end else if (inc) begin
            if (value_r >= 4'd9) begin
                value_r <= 4'd0;
            end else begin
                value_r <= value_r + 4'd1;
            end
        end else begin
            value_r <= value_r;
        end
    end

    assign carry_out = inc & (value_r == 4'd9);
    assign value     = value_r;

endmodule

// File: rtl/seq_hit_counter.sv
// Counts detector hits as two BCD digits and drives a multiplexed 2-digit
// 7-segment display; hit/ovf pulse for one cycle per counted detection.
module seq_hit_counter
    import seq_pkg::*;
#(
    parameter bit COUNT_EDGES    = 1'b1,
    parameter int REFRESH_DIV    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       z,
    input  logic       en,
    input  logic       clr,
    output logic       hit,
    output logic       ovf,
    output logic [3:0] count_tens,
    output logic [3:0] count_ones,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int              REF_W   = $clog2(REFRESH_DIV);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
    localparam logic [1:0]      AN_ONES = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;

    trk_state_t       state_r;
    trk_state_t       state_nx_s;
    logic             edge_s;
    logic             detect_s;
    logic             count_s;
    logic             ones_carry_s;
    logic             tens_carry_s;
    logic             hit_r;
    logic             ovf_r;
    logic [REF_W-1:0] refresh_r;
    logic             sel_r;
    logic [1:0]       an_r;
    logic [3:0]       digit_s;
    logic [6:0]       seg_raw_s;

    // Tracker state register; tracks z even while counting is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_LOW;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Tracker next-state and detect event.
    always_comb begin
        state_nx_s = state_r;
        edge_s     = 1'b0;
        case (state_r)
            S_LOW: begin
                if (z) begin
                    state_nx_s = S_HIGH;
                    edge_s     = 1'b1;
                end else begin
                    state_nx_s = S_LOW;
                end
            end
            S_HIGH: begin
                if (z) begin
                    state_nx_s = S_HIGH;
                end else begin
                    state_nx_s = S_LOW;
                end
            end
            default: begin
                state_nx_s = S_LOW;
            end
        endcase
        if (COUNT_EDGES) begin
            detect_s = edge_s;
        end else begin
            detect_s = z;
        end
    end

    assign count_s = detect_s & en;

    bcd_digit u_ones (
        .clk       (clk),
        .rst       (rst),
        .inc       (count_s),
        .clr       (clr),
        .value     (count_ones),
        .carry_out (ones_carry_s)
    );

    bcd_digit u_tens (
        .clk       (clk),
        .rst       (rst),
        .inc       (ones_carry_s),
        .clr       (clr),
        .value     (count_tens),
        .carry_out (tens_carry_s)
    );

    // Event pulses; a coincident clr suppresses the wrap indication but not the hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            hit_r <= count_s;
            ovf_r <= tens_carry_s & ~clr;
        end
    end

    // Refresh divider and digit select; an is kept in output polarity.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_r <= '0;
            sel_r     <= 1'b0;
            an_r      <= AN_ONES;
        end else if (refresh_r == REF_MAX) begin
            refresh_r <= '0;
            sel_r     <= ~sel_r;
            an_r      <= {an_r[0], an_r[1]};
        end else begin
            refresh_r <= refresh_r + {{(REF_W-1){1'b0}}, 1'b1};
            sel_r     <= sel_r;
            an_r      <= an_r;
        end
    end

    // Segment decode of the currently selected registered digit.
    always_comb begin
        if (sel_r) begin
            digit_s = count_tens;
        end else begin
            digit_s = count_ones;
        end
        seg_raw_s = seg7_decode(digit_s);
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
    assign an  = an_r;
    assign hit = hit_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_seq_hit_counter.sv
// Directed bench for seq_hit_counter: edge-counting instance plus a
// level-counting instance sharing the same stimulus, REFRESH_DIV=4.
module tb_seq_hit_counter;

    logic       clk;
    logic       rst;
    logic       z;
    logic       en;
    logic       clr;
    logic       hit, ovf;
    logic [3:0] count_tens, count_ones;
    logic [6:0] seg;
    logic [1:0] an;
    logic       lv_hit, lv_ovf;
    logic [3:0] lv_tens, lv_ones;
    logic [6:0] lv_seg;
    logic [1:0] lv_an;

    int total;
    int bad;
    int cyc;
    int hits;

    // Active-low {g..a} codes written out by hand
    logic [6:0] seg_al [0:9];

    seq_hit_counter #(.COUNT_EDGES(1'b1), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .z(z), .en(en), .clr(clr),
        .hit(hit), .ovf(ovf), .count_tens(count_tens), .count_ones(count_ones),
        .seg(seg), .an(an)
    );

    seq_hit_counter #(.COUNT_EDGES(1'b0), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_lvl (
        .clk(clk), .rst(rst), .z(z), .en(en), .clr(clr),
        .hit(lv_hit), .ovf(lv_ovf), .count_tens(lv_tens), .count_ones(lv_ones),
        .seg(lv_seg), .an(lv_an)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; cyc mirrors edges since the last reset edge.
    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
        #1;
        hits = hits + int'(hit);
    endtask

    task automatic pulse();
        z = 1'b1; tick();
        z = 1'b0; tick();
    endtask

    function automatic logic [1:0] exp_an();
        return (((cyc / 4) % 2) == 1) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        seg_al[0] = 7'b1000000; seg_al[1] = 7'b1111001; seg_al[2] = 7'b0100100;
        seg_al[3] = 7'b0110000; seg_al[4] = 7'b0011001; seg_al[5] = 7'b0010010;
        seg_al[6] = 7'b0000010; seg_al[7] = 7'b1111000; seg_al[8] = 7'b0000000;
        seg_al[9] = 7'b0010000;
        total = 0; bad = 0; cyc = 0; hits = 0;
        rst = 1'b1; z = 1'b0; en = 1'b0; clr = 1'b0;

        // 1. reset state
        tick(); tick();
        chk("rst_count", 32'({count_tens, count_ones}), 32'h00);
        chk("rst_hit",   32'(hit), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_an",    32'(an),  32'b10);
        chk("rst_seg",   32'(seg), 32'b1000000);
        rst = 1'b0;

        // 2. z high 3 cycles: one edge, three level detections
        en = 1'b1; z = 1'b1; hits = 0;
        tick();
        chk("edge_hit_lat", 32'(hit), 32'd1);
        chk("edge_cnt_lat", 32'({count_tens, count_ones}), 32'h01);
        tick(); tick();
        z = 1'b0; tick(); tick();
        chk("edge_hits", 32'(hits), 32'd1);
        chk("edge_count", 32'({count_tens, count_ones}), 32'h01);
        chk("level_count", 32'({lv_tens, lv_ones}), 32'h03);

        // back-to-back 1-0-1: two hits two cycles apart
        z = 1'b1; tick();
        chk("b2b_hit0", 32'(hit), 32'd1);
        z = 1'b0; tick();
        chk("b2b_gap", 32'(hit), 32'd0);
        z = 1'b1; tick();
        chk("b2b_hit1", 32'(hit), 32'd1);
        chk("b2b_count", 32'({count_tens, count_ones}), 32'h03);
        z = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;

        // 3. 99 detections, then the wrap
        for (int i = 0; i < 99; i++) pulse();
        chk("count_99", 32'({count_tens, count_ones}), 32'h99);
        z = 1'b1; tick();
        chk("wrap_hit",   32'(hit), 32'd1);
        chk("wrap_ovf",   32'(ovf), 32'd1);
        chk("wrap_count", 32'({count_tens, count_ones}), 32'h00);
        z = 1'b0; tick();
        chk("ovf_pulse", 32'(ovf), 32'd0);

        // 4. disabled counting, then enable while z is high
        en = 1'b0;
        for (int i = 0; i < 5; i++) pulse();
        chk("en0_count", 32'({count_tens, count_ones}), 32'h00);
        z = 1'b1; tick();
        hits = 0;
        en = 1'b1; tick(); tick();
        chk("en_rise_nohit", 32'(hits), 32'd0);
        z = 1'b0; tick();
        z = 1'b1; tick();
        chk("reedge_hit", 32'(hit), 32'd1);
        chk("reedge_count", 32'({count_tens, count_ones}), 32'h01);
        z = 1'b0; tick();

        // 5. clr coincident with a detect at 42
        for (int i = 0; i < 41; i++) pulse();
        chk("count_42", 32'({count_tens, count_ones}), 32'h42);
        z = 1'b1; clr = 1'b1; tick();
        chk("clr_hit",   32'(hit), 32'd1);
        chk("clr_count", 32'({count_tens, count_ones}), 32'h00);
        chk("clr_ovf",   32'(ovf), 32'd0);
        clr = 1'b0; z = 1'b0; tick();

        // 6. display multiplexing at 37
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 37; i++) pulse();
        chk("count_37", 32'({count_tens, count_ones}), 32'h37);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mux_an", 32'(an), 32'(exp_an()));
            chk("mux_seg", 32'(seg), (exp_an() == 2'b10) ? 32'(seg_al[7]) : 32'(seg_al[3]));
        end
        // park on the tens digit, then reset mid-window
        while (exp_an() != 2'b01) tick();
        tick();
        chk("tens_an", 32'(an), 32'b01);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_an",  32'(an),  32'b10);
        chk("midrst_seg", 32'(seg), 32'b1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
